nx_axi4s_packer: RTL and testbench



---
 rtl/nx_axi4s_packer_if.sv | 37 +++
 rtl/nx_axi4s_packer.sv | 156 +++++++++++++++
 tb/tb_nx_axi4s_packer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_axi4s_packer_if.sv
// nx_axi4s_packer_if
//   Bundles the Nexus outbound message port, the flush request and the
//   AXI4-stream egress of the packer into one connection.
//   master : packer side (accepts messages, drives the AXI4-stream beat)
//   slave  : surrounding logic (offers messages, sinks the beat)
//   Signals:
//     ib_nx_data_i[30:0], ib_nx_valid_i, ib_nx_ready_o  Nexus message handshake
//     flush_i                                           flush pulse
//     ob_axi4s_tdata_o/tkeep_o/tlast_o/tvalid_o, ob_axi4s_tready_i  egress
//     idle_o                                            packer empty
interface nx_axi4s_packer_if #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8
);
  logic [30:0]                ib_nx_data_i;
  logic                       ib_nx_valid_i;
  logic                       ib_nx_ready_o;
  logic                       flush_i;
  logic [AXI4_DATA_WIDTH-1:0] ob_axi4s_tdata_o;
  logic [AXI4_STRB_WIDTH-1:0] ob_axi4s_tkeep_o;
  logic                       ob_axi4s_tlast_o;
  logic                       ob_axi4s_tvalid_o;
  logic                       ob_axi4s_tready_i;
  logic                       idle_o;

  modport master (
    input  ib_nx_data_i, ib_nx_valid_i, flush_i, ob_axi4s_tready_i,
    output ib_nx_ready_o, ob_axi4s_tdata_o, ob_axi4s_tkeep_o,
           ob_axi4s_tlast_o, ob_axi4s_tvalid_o, idle_o
  );

  modport slave (
    output ib_nx_data_i, ib_nx_valid_i, flush_i, ob_axi4s_tready_i,
    input  ib_nx_ready_o, ob_axi4s_tdata_o, ob_axi4s_tkeep_o,
           ob_axi4s_tlast_o, ob_axi4s_tvalid_o, idle_o
  );
endinterface

// File: rtl/nx_axi4s_packer.sv
// nx_axi4s_packer
//   Packs 31-bit Nexus outbound messages into AXI4-stream beats of SLOTS
//   32-bit slots (message in bits 30:0 of a slot, bit 31 zero). A partial
//   beat leaves early on an idle timeout or a flush request; bursts are
//   closed with TLAST on timeout/flush or after MAX_BURST beats.
//   Ports:
//     clk_i   clock, rising edge
//     rstn_i  asynchronous active-low reset
//     bus     nx_axi4s_packer_if.master (message in, flush, AXI4-stream out, idle)
module nx_axi4s_packer #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int SLOTS           = AXI4_DATA_WIDTH / 32,
  parameter int FLUSH_CYCLES    = 16,
  parameter int MAX_BURST       = 16
) (
  input logic                clk_i,
  input logic                rstn_i,
  nx_axi4s_packer_if.master  bus
);

  localparam int FILL_W = $clog2(SLOTS + 1);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(SLOTS);
  localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);
  localparam logic [7:0]        FLUSH_THR  = 8'(FLUSH_CYCLES);
  localparam logic [7:0]        BURST_LAST = 8'(MAX_BURST - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [AXI4_DATA_WIDTH-1:0] pack_slots(
    input logic [SLOTS-1:0][30:0] s
  );
    logic [AXI4_DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < SLOTS; i++) begin
      r[32*i +: 32] = {1'b0, s[i]};
    end
    return r;
  endfunction

  function automatic logic [AXI4_STRB_WIDTH-1:0] keep_for_fill(
    input logic [FILL_W-1:0] f
  );
    logic [AXI4_STRB_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < SLOTS; i++) begin
      r[4*i +: 4] = (FILL_W'(i) < f) ? 4'hF : 4'h0;
    end
    return r;
  endfunction

  logic [SLOTS-1:0][30:0]     acc_p0;
  logic [FILL_W-1:0]          fill_p0;
  logic [7:0]                 idle_cnt;
  logic [7:0]                 burst_cnt;
  logic                       flush_pend;

  logic                       vld_p1;
  logic [AXI4_DATA_WIDTH-1:0] data_p1;
  logic [AXI4_STRB_WIDTH-1:0] keep_p1;
  logic                       last_p1;

  logic out_free;
  logic timeout;
  logic has_data;
  logic full;
  logic emit_req;
  logic xfer;
  logic last_next;
  logic in_ready;
  logic accept;

  always_comb begin
    out_free  = !vld_p1 | bus.ob_axi4s_tready_i;
    timeout   = idle_cnt >= FLUSH_THR;
    has_data  = fill_p0 != '0;
    full      = fill_p0 == FILL_FULL;
    emit_req  = full | (has_data & (timeout | flush_pend));
    xfer      = emit_req & out_free;
    // A flush landing in the same cycle as a full emission closes the burst
    // on that beat rather than being left pending on an empty accumulator.
    last_next = timeout | flush_pend | bus.flush_i | (burst_cnt == BURST_LAST);
    // A message offered in a transfer cycle lands in slot 0 of the fresh
    // accumulator, so a full accumulator still accepts while it drains.
    in_ready  = rstn_i & (!full | xfer);
    accept    = bus.ib_nx_valid_i & in_ready;
  end

  // ---- stage p0: message accumulator and burst control ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_p0     <= '0;
      fill_p0    <= '0;
      idle_cnt   <= '0;
      burst_cnt  <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (xfer) begin
        // Clearing on departure keeps unfilled slots zero in the next beat.
        acc_p0 <= '0;
        if (accept) begin
          acc_p0[0] <= bus.ib_nx_data_i;
        end
        fill_p0 <= accept ? FILL_ONE : '0;
      end else if (accept) begin
        acc_p0[fill_p0[SLOT_W-1:0]] <= bus.ib_nx_data_i;
        fill_p0 <= fill_p0 + FILL_ONE;
      end

      if (accept || !has_data) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= sat_inc8(idle_cnt);
      end

      if (xfer) begin
        flush_pend <= 1'b0;
      end else if (bus.flush_i && has_data) begin
        flush_pend <= 1'b1;
      end

      if (xfer) begin
        burst_cnt <= last_next ? 8'd0 : burst_cnt + 8'd1;
      end
    end
  end

  // ---- stage p1: registered AXI4-stream output ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= pack_slots(acc_p0);
      keep_p1 <= keep_for_fill(fill_p0);
      last_p1 <= last_next;
    end else if (bus.ob_axi4s_tready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.ib_nx_ready_o     = in_ready;
  assign bus.ob_axi4s_tvalid_o = vld_p1;
  assign bus.ob_axi4s_tdata_o  = data_p1;
  assign bus.ob_axi4s_tkeep_o  = keep_p1;
  assign bus.ob_axi4s_tlast_o  = last_p1;
  assign bus.idle_o            = !has_data & !vld_p1;

endmodule

// File: tb/tb_nx_axi4s_packer.sv
// tb_nx_axi4s_packer
//   Directed bench for nx_axi4s_packer at default parameters. A queue-based
//   reference model predicts the outputs every cycle; directed sections pin
//   the model with hand-computed beats.
module tb_nx_axi4s_packer;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int SL = 4;
  localparam int FC = 16;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rstn_i = 1'b1;

  nx_axi4s_packer_if #(.AXI4_DATA_WIDTH(DW), .AXI4_STRB_WIDTH(KW)) bus ();

  nx_axi4s_packer #(
    .AXI4_DATA_WIDTH(DW),
    .AXI4_STRB_WIDTH(KW),
    .SLOTS(SL),
    .FLUSH_CYCLES(FC),
    .MAX_BURST(MB)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn_i),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int stalls  = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void check_int(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Reference model: pending messages in a queue, output beat as plain values.
  int           m_acc[$];
  bit           m_vld;
  logic [127:0] m_data;
  logic [15:0]  m_keep;
  bit           m_last;
  int           m_idle;
  int           m_burst;
  bit           m_fpend;

  logic [127:0] log_data[$];
  logic [15:0]  log_keep[$];
  bit           log_last[$];

  function automatic void model_reset();
    m_acc.delete();
    m_vld = 0; m_data = '0; m_keep = '0; m_last = 0;
    m_idle = 0; m_burst = 0; m_fpend = 0;
  endfunction

  bit chk_en = 0;
  int c_fill;
  bit c_to, c_emit, c_xfer, c_rdy, c_acc, c_last;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rstn_i) begin
        model_reset();
        check_int("rst_tvalid", int'(bus.ob_axi4s_tvalid_o), 0);
        check("rst_tdata", bus.ob_axi4s_tdata_o, '0);
        check("rst_tkeep", 128'(bus.ob_axi4s_tkeep_o), '0);
        check_int("rst_tlast", int'(bus.ob_axi4s_tlast_o), 0);
        check_int("rst_ready", int'(bus.ib_nx_ready_o), 0);
        check_int("rst_idle", int'(bus.idle_o), 1);
      end else begin
        c_fill = m_acc.size();
        c_to   = m_idle >= FC;
        c_emit = (c_fill == SL) || (c_fill > 0 && (c_to || m_fpend));
        c_xfer = c_emit && (!m_vld || bus.ob_axi4s_tready_i);
        c_rdy  = (c_fill < SL) || c_xfer;

        check_int("cyc_tvalid", int'(bus.ob_axi4s_tvalid_o), int'(m_vld));
        check("cyc_tdata", bus.ob_axi4s_tdata_o, m_data);
        check("cyc_tkeep", 128'(bus.ob_axi4s_tkeep_o), 128'(m_keep));
        check_int("cyc_tlast", int'(bus.ob_axi4s_tlast_o), int'(m_last));
        check_int("cyc_ready", int'(bus.ib_nx_ready_o), int'(c_rdy));
        check_int("cyc_idle", int'(bus.idle_o), int'(c_fill == 0 && !m_vld));

        if (bus.ob_axi4s_tvalid_o && bus.ob_axi4s_tready_i) begin
          log_data.push_back(bus.ob_axi4s_tdata_o);
          log_keep.push_back(bus.ob_axi4s_tkeep_o);
          log_last.push_back(bus.ob_axi4s_tlast_o);
        end

        // Advance the model across the coming rising edge.
        c_acc  = bus.ib_nx_valid_i && c_rdy;
        c_last = c_to || m_fpend || bus.flush_i || (m_burst == MB - 1);
        if (c_xfer) begin
          m_vld  = 1;
          m_data = '0;
          for (int i = 0; i < c_fill; i++) m_data = m_data | (128'(m_acc[i]) << (32 * i));
          m_keep = 16'((64'd1 << (4 * c_fill)) - 64'd1);
          m_last = c_last;
          m_burst = c_last ? 0 : m_burst + 1;
          m_fpend = 0;
          m_acc.delete();
        end else begin
          if (bus.ob_axi4s_tready_i) m_vld = 0;
          if (bus.flush_i && c_fill > 0) m_fpend = 1;
        end
        if (c_acc || c_fill == 0) m_idle = 0;
        else if (m_idle < 255) m_idle++;
        if (c_acc) m_acc.push_back(int'(bus.ib_nx_data_i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [30:0] d);
    bit ok;
    ok = 0;
    bus.ib_nx_data_i  = d;
    bus.ib_nx_valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.ib_nx_ready_o) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) check_int("send_timeout", 0, 1);
    tick();
    bus.ib_nx_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (log_data.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_int(name, log_data.size(), n);
  endtask

  task automatic pulse_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  int base;
  int acc_cnt;
  int nlast;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.ib_nx_data_i      = '0;
    bus.ib_nx_valid_i     = 1'b0;
    bus.flush_i           = 1'b0;
    bus.ob_axi4s_tready_i = 1'b1;
    #2;
    rstn_i = 1'b0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    check_int("init_idle", int'(bus.idle_o), 1);
    check_int("init_ready_low", int'(bus.ib_nx_ready_o), 0);
    rstn_i = 1'b1;
    tick();

    // Four messages -> one full beat the cycle after the fourth accept.
    base = log_data.size();
    stalls = 0;
    for (int i = 1; i <= 4; i++) send(31'(i));
    tick();
    check_int("t1_latency_tvalid", int'(bus.ob_axi4s_tvalid_o), 1);
    wait_beats(base + 1, 10, "t1_beat_count");
    check("t1_tdata", log_data[base], 128'h00000004_00000003_00000002_00000001);
    check("t1_tkeep", 128'(log_keep[base]), 128'hFFFF);
    check_int("t1_tlast", int'(log_last[base]), 0);
    check_int("t1_no_stall", stalls, 0);

    // Two messages then idle -> timeout beat with two slots and TLAST.
    base = log_data.size();
    send(31'h5);
    send(31'h6);
    wait_beats(base + 1, 40, "t2_beat_count");
    check("t2_tdata", log_data[base], 128'h00000000_00000000_00000006_00000005);
    check("t2_tkeep", 128'(log_keep[base]), 128'h00FF);
    check_int("t2_tlast", int'(log_last[base]), 1);
    tick();
    check_int("t2_idle_back", int'(bus.idle_o), 1);

    // Three messages then flush -> three-slot beat with TLAST.
    base = log_data.size();
    send(31'h7);
    send(31'h8);
    send(31'h9);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    tick();
    check_int("t3_flush_latency_tvalid", int'(bus.ob_axi4s_tvalid_o), 1);
    wait_beats(base + 1, 10, "t3_beat_count");
    check("t3_tdata", log_data[base], 128'h00000000_00000009_00000008_00000007);
    check("t3_tkeep", 128'(log_keep[base]), 128'h0FFF);
    check_int("t3_tlast", int'(log_last[base]), 1);
    // Flush on an empty accumulator produces nothing.
    repeat (3) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    repeat (30) tick();
    check_int("t3_empty_flush_no_beat", log_data.size(), base + 1);
    check_int("t3_empty_flush_tvalid", int'(bus.ob_axi4s_tvalid_o), 0);

    // Back-pressure: ten messages offered with tready low.
    base = log_data.size();
    acc_cnt = 0;
    bus.ob_axi4s_tready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(31'h11 + 31'(i));
          acc_cnt++;
        end
      end
      begin
        repeat (20) tick();
        check_int("t4_accepts_stalled", acc_cnt, 8);
        check_int("t4_ready_low", int'(bus.ib_nx_ready_o), 0);
        check_int("t4_held_tvalid", int'(bus.ob_axi4s_tvalid_o), 1);
        check("t4_held_tdata", bus.ob_axi4s_tdata_o, 128'h00000014_00000013_00000012_00000011);
        bus.ob_axi4s_tready_i = 1'b1;
      end
    join
    wait_beats(base + 3, 60, "t4_beat_count");
    check("t4_beat0", log_data[base], 128'h00000014_00000013_00000012_00000011);
    check("t4_beat1", log_data[base + 1], 128'h00000018_00000017_00000016_00000015);
    check("t4_beat2", log_data[base + 2], 128'h00000000_00000000_0000001A_00000019);
    check("t4_beat2_tkeep", 128'(log_keep[base + 2]), 128'h00FF);
    check_int("t4_beat2_tlast", int'(log_last[base + 2]), 1);
    repeat (4) tick();
    check_int("t4_no_extra", log_data.size(), base + 3);

    // 68 back-to-back messages: 16-beat burst, then a new burst.
    pulse_reset();
    base = log_data.size();
    stalls = 0;
    for (int i = 0; i < 68; i++) send(31'h100 + 31'(i));
    wait_beats(base + 17, 20, "t5_beat_count");
    check_int("t5_no_stall", stalls, 0);
    nlast = 0;
    for (int i = 0; i < 16; i++) nlast += int'(log_last[base + i]);
    check_int("t5_tlast_count", nlast, 1);
    check_int("t5_tlast_16th", int'(log_last[base + 15]), 1);
    check_int("t5_tlast_17th", int'(log_last[base + 16]), 0);
    check("t5_beat0", log_data[base], 128'h00000103_00000102_00000101_00000100);
    check("t5_beat16", log_data[base + 16], 128'h00000143_00000142_00000141_00000140);

    // Reset while a beat is held and two messages are accumulated.
    repeat (3) tick();
    base = log_data.size();
    bus.ob_axi4s_tready_i = 1'b0;
    for (int i = 0; i < 6; i++) send(31'h21 + 31'(i));
    tick();
    check_int("t6_held_tvalid", int'(bus.ob_axi4s_tvalid_o), 1);
    check_int("t6_not_idle", int'(bus.idle_o), 0);
    rstn_i = 1'b0;
    #1;
    check_int("t6_rst_tvalid", int'(bus.ob_axi4s_tvalid_o), 0);
    check("t6_rst_tdata", bus.ob_axi4s_tdata_o, '0);
    check("t6_rst_tkeep", 128'(bus.ob_axi4s_tkeep_o), '0);
    tick();
    rstn_i = 1'b1;
    bus.ob_axi4s_tready_i = 1'b1;
    repeat (30) tick();
    check_int("t6_no_stale_beat", log_data.size(), base);
    check_int("t6_idle_after", int'(bus.idle_o), 1);
    for (int i = 0; i < 4; i++) send(31'h31 + 31'(i));
    wait_beats(base + 1, 10, "t6_beat_count");
    check("t6_clean_tdata", log_data[base], 128'h00000034_00000033_00000032_00000031);
    check("t6_clean_tkeep", 128'(log_keep[base]), 128'hFFFF);
    check_int("t6_clean_tlast", int'(log_last[base]), 0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
